bundle_queue: RTL and testbench
===============================

Name: bundle_queue

Overview:
- Parametrised multi-port, in-order FIFO for pipeline bundles (fetch, decode and rename bundles) between frontend and backend stages.
- Accepts up to IW bundles per cycle and presents the oldest OW bundles per cycle.
- Supports a full flush and a partial rollback kill. The kill removes every queued entry whose 16-bit opid is strictly younger than a redirect opid.
- Generalises fixed single-width stage latches into one block configurable in bundle width, depth and port count.

Parameters:
- W, 64: bundle width in bits; instantiated with the $bits of the carried bundle type.
- DEPTH, 16: number of entries; power of two, at least max(IW, OW).
- IW, 2: number of enqueue ports.
- OW, 2: number of dequeue ports.
- OPID_LSB, 0: bit position of the 16-bit opid field inside the bundle. The opid MSB is its valid bit; bits [14:0] are a wrapping sequence number.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all entries.
- kill_valid  in  1  partial rollback request.
- kill_opid  in  16  rollback point; entries younger than this are removed.
- in_valid  in  IW  enqueue valid, thermometer-coded from bit 0.
- in_data  in  IW*W  enqueue bundles; slot 0 is the oldest.
- in_ready  out  1  enqueue accepted this cycle when high.
- out_valid  out  OW  oldest entries present, thermometer-coded.
- out_data  out  OW*W  oldest entries; slot 0 is the head.
- out_ready  in  OW  consumer accept, per slot.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous, active-high.
  - While rst is high: head=0, tail=0, count=0, out_valid=0, in_ready=0. Storage contents are don't-care.
  - The first cycle after rst deasserts: in_ready=1.
- Storage and pointers:
  - Circular buffer with log2(DEPTH)-bit head and tail pointers. Wrap-around is modulo DEPTH.
  - count is held in a separate register and is the authority for full and empty.
- in_ready:
  - in_ready = (DEPTH - count >= IW) and not rst.
  - It depends only on registered state; it never combinationally depends on the same-cycle pop.
- Enqueue:
  - Occurs when in_ready=1, flush=0 and kill_valid=0.
  - All in_valid slots are written at tail, tail+1, and so on, then tail += popcount(in_valid).
  - A non-thermometer in_valid is illegal (assertion in simulation). Only the leading contiguous ones are written.
- Output presentation:
  - out_valid[i] = (i < count). out_data[i] = entry[head+i].
  - Combinational read of registered storage, so there is zero-cycle visibility of data already stored.
  - A bundle enqueued in cycle t is first visible at the outputs in cycle t+1.
- Dequeue:
  - pop = number of leading ones of (out_valid & out_ready). Bits after the first zero are ignored.
  - head += pop; this also applies in kill cycles.
- Kill:
  - Age rule: entry e is younger than k iff both opid valid bits are set and ((e.opid[14:0] - k[14:0]) mod 2^15) lies in [1, 2^14-1].
  - Entries with opid valid=0 are never younger.
  - Entries are in program order, so the killed entries form a contiguous suffix at the tail.
  - kept = number of leading non-younger entries from head within count.
  - Next state: tail = head_next + (kept - popped_from_kept), count = kept - pop. Popped entries are taken from the kept prefix.
  - A bundle equal to kill_opid is kept.
  - Enqueue is suppressed in a kill cycle. The producer holds its bundles; the redirect normally invalidates them anyway.
- Flush:
  - head=tail=0, count=0 next cycle.
  - Overrides kill, enqueue and pop. Any out_ready in that cycle is still a consumer-side handshake, but queue state is cleared.
- count update without kill or flush: count_next = count + pushed - pop.
- Full boundary: with count=DEPTH, in_ready=0. With count=DEPTH-IW+1, in_ready=0 even if a pop happens that cycle, which gives deterministic timing.
- Empty boundary: with count=0, out_valid=0. There is no enqueue-to-dequeue bypass.
- Reset mid-operation: rst takes effect at the next edge, clears everything, and overrides flush and kill.

Decomposition:
- Add to the shared types package:
  - a function opid_younger(logic [15:0] a, b) implementing the age rule;
  - a localparam OPID_SEQ_BITS = 15.
- Sub-module bq_kill_scan:
  - Combinational; inputs are head, count, the storage opids and kill_opid.
  - Output is kept, a leading-count over DEPTH comparators.
  - Keeps the queue RTL to pointer and count logic.

Test Plan:
- Reset, then IW=2 enqueue of opids 0x8001 and 0x8002 -> next cycle count=2, out_valid=2'b11, out_data[0] opid=0x8001; out_ready=2'b01 -> count=1, out_data[0] opid=0x8002.
- Fill a DEPTH=16 queue with 15 entries -> in_ready=0. Pop 1 with out_ready=01 -> in_ready stays 0 that cycle and is 1 the next cycle (count=14).
- Wrap: do 40 cycles of 2-in/2-out traffic with sequential opids -> output stream equals input order exactly; head and tail wrap with no loss.
- Kill: queue holds opids 0x8005..0x800C; kill_opid=0x8008 -> next cycle count=4, tail entry opid 0x8008. A same-cycle in_valid=11 is not enqueued.
- Kill across sequence wrap: queue holds 0xFFFE, 0xFFFF, 0x8000, 0x8001; kill_opid=0xFFFF -> kept 0xFFFE and 0xFFFF, count=2.
- Simultaneous events: flush, kill_valid, in_valid=11 and out_ready=11 together with count=5 -> next cycle count=0, out_valid=0. Then assert rst with count=7 -> count=0 and in_ready=0 during reset.

Source files
------------

// File: rtl/bundle_queue_pkg.sv
// Shared types and helpers for the bundle queue: opid layout and the age rule.
// Latency: n/a (package).
// Backpressure: n/a (package).
package bundle_queue_pkg;

    localparam int OPID_BITS     = 16;
    localparam int OPID_SEQ_BITS = 15;

    typedef logic [OPID_BITS-1:0] opid_t;

    // a is younger than b when both carry a valid opid and the wrapping
    // sequence distance a-b falls in the forward half-window [1, 2^14-1].
    function automatic logic opid_younger(input opid_t a, input opid_t b);
        logic [OPID_SEQ_BITS-1:0] d;
        d = a[OPID_SEQ_BITS-1:0] - b[OPID_SEQ_BITS-1:0];
        return a[OPID_BITS-1] && b[OPID_BITS-1] && (d != '0) && !d[OPID_SEQ_BITS-1];
    endfunction

endpackage

// File: rtl/bundle_queue_kill_scan.sv
// Rollback scan: counts leading queued entries from head that survive a kill.
// Latency: combinational.
// Backpressure: none; pure function of queue state and kill_opid.
// Ports: i_head/i_count (queue state), i_opids (opid of every slot),
//        i_kill_opid (rollback point), o_kept (surviving prefix length).
module bq_kill_scan
    import bundle_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic [PW-1:0]      i_head,
    input  logic [CW-1:0]      i_count,
    input  opid_t [DEPTH-1:0]  i_opids,
    input  opid_t              i_kill_opid,
    output logic [CW-1:0]      o_kept
);

    // Entries sit in program order, so the first younger entry marks the
    // start of the killed suffix; everything after it is discarded too.
    always_comb begin
        logic          w_stop;
        logic [PW-1:0] w_idx;
        o_kept = '0;
        w_stop = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + PW'(i);
            if (!w_stop && (CW'(i) < i_count) &&
                !opid_younger(i_opids[w_idx], i_kill_opid))
                o_kept = o_kept + CW'(1);
            else
                w_stop = 1'b1;
        end
    end

endmodule

// File: rtl/bundle_queue.sv
// Multi-port in-order bundle FIFO with full flush and opid-based rollback kill.
// Latency: enqueue visible at outputs one cycle later; reads are combinational from storage.
// Backpressure: in_ready from registered count only (needs IW free slots); per-slot out_ready, leading ones pop.
// Ports: clk/rst (sync active-high), flush, kill_valid/kill_opid, in_valid/in_data/in_ready,
//        out_valid/out_data/out_ready, count (occupancy).
module bundle_queue
    import bundle_queue_pkg::*;
#(
    parameter int W        = 64,
    parameter int DEPTH    = 16,
    parameter int IW       = 2,
    parameter int OW       = 2,
    parameter int OPID_LSB = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        kill_valid,
    input  logic [15:0]                 kill_opid,
    input  logic [IW-1:0]               in_valid,
    input  logic [IW*W-1:0]             in_data,
    output logic                        in_ready,
    output logic [OW-1:0]               out_valid,
    output logic [OW*W-1:0]             out_data,
    input  logic [OW-1:0]               out_ready,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]      r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic              w_enq;
    logic [CW-1:0]     w_push;
    logic [CW-1:0]     w_pop;
    logic [CW-1:0]     w_pop_k;
    logic [CW-1:0]     w_kept;
    opid_t [DEPTH-1:0] w_opids;

    assign count    = r_count;
    // Registered-state-only ready: a same-cycle pop never opens a slot.
    assign in_ready = !rst && (r_count <= CW'(DEPTH - IW));
    assign w_enq    = in_ready && !flush && !kill_valid;

    for (genvar i = 0; i < OW; i++) begin : g_out
        assign out_valid[i]         = CW'(i) < r_count;
        assign out_data[i*W +: W]   = r_mem[r_head + PW'(i)];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_opid
        assign w_opids[i] = r_mem[i][OPID_LSB +: 16];
    end

    // Leading-ones counts: a gap in the valid/ready pattern ends the burst.
    always_comb begin
        logic w_run;
        w_push = '0;
        w_run  = w_enq;
        for (int j = 0; j < IW; j++) begin
            if (w_run && in_valid[j]) w_push = w_push + CW'(1);
            else                      w_run  = 1'b0;
        end
    end

    always_comb begin
        logic w_run;
        w_pop = '0;
        w_run = 1'b1;
        for (int i = 0; i < OW; i++) begin
            if (w_run && out_valid[i] && out_ready[i]) w_pop = w_pop + CW'(1);
            else                                       w_run = 1'b0;
        end
    end

    // In a kill cycle only the surviving prefix can be consumed.
    assign w_pop_k = (w_pop > w_kept) ? w_kept : w_pop;

    bq_kill_scan #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW)
    ) u_kill_scan (
        .i_head      (r_head),
        .i_count     (r_count),
        .i_opids     (w_opids),
        .i_kill_opid (kill_opid),
        .o_kept      (w_kept)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (kill_valid) begin
            r_head  <= r_head + PW'(w_pop_k);
            // Tail lands just past the last kept entry (kept may equal DEPTH).
            r_tail  <= r_head + PW'(w_kept);
            r_count <= w_kept - w_pop_k;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_push);
            r_count <= r_count + w_push - w_pop;
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        for (int j = 0; j < IW; j++) begin
            if (CW'(j) < w_push)
                r_mem[r_tail + PW'(j)] <= in_data[j*W +: W];
        end
    end

    a_in_valid_thermo: assert property (@(posedge clk) disable iff (rst)
        ((in_valid & (in_valid + IW'(1))) == '0));

endmodule

// File: tb/tb_bundle_queue.sv
module tb_bundle_queue;

    localparam int W     = 64;
    localparam int DEPTH = 16;
    localparam int IW    = 2;
    localparam int OW    = 2;
    localparam int CW    = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              kill_valid;
    logic [15:0]       kill_opid;
    logic [IW-1:0]     in_valid;
    logic [IW*W-1:0]   in_data;
    logic              in_ready;
    logic [OW-1:0]     out_valid;
    logic [OW*W-1:0]   out_data;
    logic [OW-1:0]     out_ready;
    logic [CW-1:0]     count;

    logic [W-1:0]      q[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    logic [14:0]       seq;

    always #5 clk = ~clk;

    bundle_queue #(.W(W), .DEPTH(DEPTH), .IW(IW), .OW(OW), .OPID_LSB(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .kill_valid (kill_valid),
        .kill_opid  (kill_opid),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .count      (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Age rule from plain integer arithmetic on the sequence numbers.
    function automatic bit younger(input int e, input int k);
        int d;
        if (((e >> 15) & 1) == 0 || ((k >> 15) & 1) == 0) return 0;
        d = ((e & 32767) - (k & 32767) + 32768) % 32768;
        return (d >= 1) && (d <= 16383);
    endfunction

    function automatic logic [W-1:0] mk(input logic [15:0] opid);
        return {32'($urandom), 16'($urandom), opid};
    endfunction

    task automatic idle();
        flush = 0; kill_valid = 0; kill_opid = '0;
        in_valid = '0; out_ready = '0;
    endtask

    task automatic put2(input logic [15:0] a, input logic [15:0] b);
        in_valid = 2'b11;
        in_data  = {mk(b), mk(a)};
    endtask

    task automatic put1(input logic [15:0] a);
        in_valid = 2'b01;
        in_data  = {mk(16'h0), mk(a)};
    endtask

    // Check outputs against the model on the falling edge, then advance the
    // model with the rules applied to this cycle's inputs.
    task automatic cyc();
        int sz, pop, kept;
        bit run;
        @(negedge clk);
        sz = q.size();
        chk("count", 64'(count), 64'(sz));
        chk("in_ready", 64'(in_ready), (!rst && (DEPTH - sz >= IW)) ? 64'd1 : 64'd0);
        for (int i = 0; i < OW; i++) begin
            chk("out_valid", 64'(out_valid[i]), (i < sz) ? 64'd1 : 64'd0);
            if (i < sz) chk("out_data", out_data[i*W +: W], q[i]);
        end
        if (rst || flush) begin
            q.delete();
        end else begin
            pop = 0; run = 1;
            for (int i = 0; i < OW; i++) begin
                if (run && i < sz && out_ready[i]) pop++;
                else run = 0;
            end
            if (kill_valid) begin
                kept = 0; run = 1;
                for (int i = 0; i < sz; i++) begin
                    if (run && !younger(int'(q[i][15:0]), int'(kill_opid))) kept++;
                    else run = 0;
                end
                while (q.size() > kept) void'(q.pop_back());
                if (pop > kept) pop = kept;
            end else if (DEPTH - sz >= IW) begin
                run = 1;
                for (int j = 0; j < IW; j++) begin
                    if (run && in_valid[j]) q.push_back(in_data[j*W +: W]);
                    else run = 0;
                end
            end
            repeat (pop) void'(q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        in_data = '0;
        rst = 1;
        @(posedge clk); #1;
        cyc();
        rst = 0;
        cyc();

        // Basic two-wide enqueue then single pop.
        put2(16'h8001, 16'h8002); cyc(); idle();
        chk("enq_count", 64'(count), 64'd2);
        chk("enq_valid", 64'(out_valid), 64'b11);
        chk("enq_head_opid", 64'(out_data[15:0]), 64'h8001);
        out_ready = 2'b01; cyc(); idle();
        chk("pop1_count", 64'(count), 64'd1);
        chk("pop1_head_opid", 64'(out_data[15:0]), 64'h8002);

        // Full boundary.
        flush = 1; cyc(); idle();
        for (int i = 0; i < 7; i++) begin put2(16'h8100 + 16'(2*i), 16'h8101 + 16'(2*i)); cyc(); end
        put1(16'h810E); cyc(); idle();
        chk("full_count", 64'(count), 64'd15);
        chk("full_rdy", 64'(in_ready), 64'd0);
        put2(16'h8110, 16'h8111); out_ready = 2'b01; cyc(); idle();
        chk("full_pop_count", 64'(count), 64'd14);
        chk("full_pop_rdy", 64'(in_ready), 64'd1);

        // Wrap traffic, 2 in / 2 out with sequential opids.
        flush = 1; cyc(); idle();
        seq = 15'd0;
        for (int i = 0; i < 40; i++) begin
            put2({1'b1, seq}, {1'b1, seq + 15'd1});
            seq = seq + 15'd2;
            out_ready = 2'b11;
            cyc();
        end
        idle();

        // Partial kill with a suppressed same-cycle enqueue.
        flush = 1; cyc(); idle();
        put2(16'h8005, 16'h8006); cyc();
        put2(16'h8007, 16'h8008); cyc();
        put2(16'h8009, 16'h800A); cyc();
        put2(16'h800B, 16'h800C); cyc();
        kill_valid = 1; kill_opid = 16'h8008; put2(16'h800D, 16'h800E); cyc(); idle();
        chk("kill_count", 64'(count), 64'd4);
        out_ready = 2'b11; cyc(); idle();
        chk("kill_tail_opid", 64'(out_data[W +: 16]), 64'h8008);
        chk("kill_after_pop", 64'(count), 64'd2);

        // Kill across sequence wrap.
        flush = 1; cyc(); idle();
        put2(16'hFFFE, 16'hFFFF); cyc();
        put2(16'h8000, 16'h8001); cyc();
        kill_valid = 1; kill_opid = 16'hFFFF; cyc(); idle();
        chk("wkill_count", 64'(count), 64'd2);
        chk("wkill_d0", 64'(out_data[15:0]), 64'hFFFE);
        chk("wkill_d1", 64'(out_data[W +: 16]), 64'hFFFF);

        // Everything at once, then reset mid-operation.
        flush = 1; cyc(); idle();
        put2(16'h8200, 16'h8201); cyc();
        put2(16'h8202, 16'h8203); cyc();
        put1(16'h8204); cyc(); idle();
        chk("sim_pre_count", 64'(count), 64'd5);
        flush = 1; kill_valid = 1; kill_opid = 16'h8201; put2(16'h8205, 16'h8206);
        out_ready = 2'b11; cyc(); idle();
        chk("sim_count", 64'(count), 64'd0);
        chk("sim_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin put2(16'h8300 + 16'(2*i), 16'h8301 + 16'(2*i)); cyc(); end
        put1(16'h8306); cyc(); idle();
        chk("rst_pre_count", 64'(count), 64'd7);
        rst = 1; put2(16'h8307, 16'h8308); cyc(); idle();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd0);
        cyc();
        rst = 0; cyc();

        // Randomised traffic with occasional kills and flushes.
        seq = 15'h7F00;
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a, b;
            int r;
            idle();
            a = {($urandom_range(0, 7) != 0), seq};
            b = {($urandom_range(0, 7) != 0), seq + 15'd1};
            seq = seq + 15'd2;
            r = int'($urandom_range(0, 2));
            if (r == 1) put1(a);
            else if (r == 2) put2(a, b);
            out_ready = 2'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                kill_valid = 1;
                kill_opid  = {($urandom_range(0, 7) != 0), seq - 15'($urandom_range(1, 12))};
            end
            if ($urandom_range(0, 49) == 0) flush = 1;
            cyc();
        end
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
